// File: rtl/decoder.sv
// Single-cycle instruction decoder: splits a 32-bit word into format-dependent
// fields and registers the result, giving one cycle of latency.
module decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [7:0]  opcode,
    output logic [3:0]  rde,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  func,
    output logic [23:0] imm,
    output logic [2:0]  instr_type
);

    localparam logic [2:0] TYPE_R   = 3'b000;
    localparam logic [2:0] TYPE_M   = 3'b001;
    localparam logic [2:0] TYPE_F   = 3'b010;
    localparam logic [2:0] TYPE_J   = 3'b011;
    localparam logic [2:0] TYPE_B   = 3'b100;
    localparam logic [2:0] TYPE_E   = 3'b101;
    localparam logic [2:0] TYPE_INV = 3'b111;

    logic [7:0]  opcode_d, opcode_q;
    logic [3:0]  rde_d, rde_q;
    logic [3:0]  rs1_d, rs1_q;
    logic [3:0]  rs2_d, rs2_q;
    logic [3:0]  func_d, func_q;
    logic [23:0] imm_d, imm_q;
    logic [2:0]  type_d, type_q;

    // Format is chosen by the opcode's upper nibble; opcode 0x00 is reserved as invalid.
    always_comb begin
        opcode_d = instruction[7:0];
        rde_d    = 4'h0;
        rs1_d    = 4'h0;
        rs2_d    = 4'h0;
        func_d   = 4'h0;
        imm_d    = 24'h0;
        type_d   = TYPE_INV;
        case (instruction[7:4])
            4'h0: begin
                if (instruction[3:0] != 4'h0) begin
                    imm_d  = instruction[31:8];
                    type_d = TYPE_E;
                end
            end
            4'h1: begin
                rde_d  = instruction[11:8];
                rs1_d  = instruction[15:12];
                rs2_d  = instruction[19:16];
                imm_d  = {16'h0, instruction[27:20]};
                func_d = instruction[31:28];
                type_d = TYPE_R;
            end
            4'h2: begin
                rde_d  = instruction[11:8];
                rs1_d  = instruction[15:12];
                imm_d  = {{12{instruction[27]}}, instruction[27:16]};
                func_d = instruction[31:28];
                type_d = TYPE_M;
            end
            4'h3: begin
                rde_d  = instruction[11:8];
                rs1_d  = instruction[15:12];
                func_d = instruction[19:16];
                imm_d  = {12'h0, instruction[31:20]};
                type_d = TYPE_F;
            end
            4'h4: begin
                rde_d  = instruction[11:8];
                imm_d  = {{4{instruction[31]}}, instruction[31:12]};
                type_d = TYPE_J;
            end
            4'h5: begin
                func_d = instruction[11:8];
                imm_d  = {{4{instruction[31]}}, instruction[31:12]};
                type_d = TYPE_B;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= 8'h00;
            rde_q    <= 4'h0;
            rs1_q    <= 4'h0;
            rs2_q    <= 4'h0;
            func_q   <= 4'h0;
            imm_q    <= 24'h0;
            type_q   <= TYPE_INV;
        end else begin
            opcode_q <= opcode_d;
            rde_q    <= rde_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            func_q   <= func_d;
            imm_q    <= imm_d;
            type_q   <= type_d;
        end
    end

    assign opcode     = opcode_q;
    assign rde        = rde_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign func       = func_q;
    assign imm        = imm_q;
    assign instr_type = type_q;

endmodule

// File: tb/tb_decoder.sv
// Randomized bench for decoder: a field-extraction model computed with integer
// arithmetic is compared against the registered outputs every cycle.
module tb_decoder;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  rde;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  func;
        logic [23:0] imm;
        logic [2:0]  itype;
    } dec_t;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [7:0]  opcode;
    logic [3:0]  rde, rs1, rs2, func;
    logic [23:0] imm;
    logic [2:0]  instr_type;

    int vectors;
    int miscompares;

    decoder dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .opcode     (opcode),
        .rde        (rde),
        .rs1        (rs1),
        .rs2        (rs2),
        .func       (func),
        .imm        (imm),
        .instr_type (instr_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned field(input logic [31:0] w, input int lsb, input int width);
        return (int'(w) >>> lsb) & ((1 << width) - 1);
    endfunction

    function automatic logic [23:0] sext(input int unsigned v, input int width);
        int s;
        s = (v >= (1 << (width - 1))) ? int'(v) - (1 << width) : int'(v);
        return 24'(s);
    endfunction

    // Expected outputs straight from the format table.
    function automatic dec_t model(input logic r, input logic [31:0] w);
        dec_t e;
        int unsigned op;
        e = '0;
        e.itype = 3'd7;
        if (r) return e;
        op = field(w, 0, 8);
        e.opcode = 8'(op);
        if (op >= 1 && op <= 15) begin
            e.imm = 24'(field(w, 8, 24));
            e.itype = 3'd5;
        end else if (op >= 16 && op <= 31) begin
            e.rde = 4'(field(w, 8, 4)); e.rs1 = 4'(field(w, 12, 4));
            e.rs2 = 4'(field(w, 16, 4)); e.imm = 24'(field(w, 20, 8));
            e.func = 4'(field(w, 28, 4)); e.itype = 3'd0;
        end else if (op >= 32 && op <= 47) begin
            e.rde = 4'(field(w, 8, 4)); e.rs1 = 4'(field(w, 12, 4));
            e.imm = sext(field(w, 16, 12), 12);
            e.func = 4'(field(w, 28, 4)); e.itype = 3'd1;
        end else if (op >= 48 && op <= 63) begin
            e.rde = 4'(field(w, 8, 4)); e.rs1 = 4'(field(w, 12, 4));
            e.func = 4'(field(w, 16, 4)); e.imm = 24'(field(w, 20, 12));
            e.itype = 3'd2;
        end else if (op >= 64 && op <= 79) begin
            e.rde = 4'(field(w, 8, 4));
            e.imm = sext(field(w, 12, 20), 20); e.itype = 3'd3;
        end else if (op >= 80 && op <= 95) begin
            e.func = 4'(field(w, 8, 4));
            e.imm = sext(field(w, 12, 20), 20); e.itype = 3'd4;
        end
        return e;
    endfunction

    function automatic dec_t dut_out();
        dec_t d;
        d.opcode = opcode; d.rde = rde; d.rs1 = rs1; d.rs2 = rs2;
        d.func = func; d.imm = imm; d.itype = instr_type;
        return d;
    endfunction

    task automatic compare(input string name, input dec_t exp);
        dec_t got;
        got = dut_out();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got op=%h rde=%h rs1=%h rs2=%h func=%h imm=%h type=%b, need op=%h rde=%h rs1=%h rs2=%h func=%h imm=%h type=%b",
                     name, got.opcode, got.rde, got.rs1, got.rs2, got.func, got.imm, got.itype,
                     exp.opcode, exp.rde, exp.rs1, exp.rs2, exp.func, exp.imm, exp.itype);
        end
    endtask

    // Apply one input pair for one edge, then check the model result at the falling edge.
    task automatic step(input logic r, input logic [31:0] w);
        dec_t exp;
        rst = r;
        instruction = w;
        exp = model(r, w);
        @(posedge clk);
        @(negedge clk);
        compare("model", exp);
    endtask

    task automatic lit(input string name, input logic [7:0] op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] f,
                       input logic [23:0] im, input logic [2:0] t);
        compare(name, {op, d, s1, s2, f, im, t});
    endtask

    logic [7:0] bounds [16];

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        instruction = 32'h0;
        bounds = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h1F, 8'h20, 8'h2F, 8'h30,
                   8'h3F, 8'h40, 8'h4F, 8'h50, 8'h5F, 8'h60, 8'h80, 8'hFF};
        @(negedge clk);

        step(1'b1, 32'hF7654311);
        lit("reset", 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0, 3'b111);
        step(1'b0, 32'h00000011);
        lit("orr", 8'h11, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0, 3'b000);
        step(1'b0, 32'h00000021);
        lit("ori", 8'h21, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0, 3'b001);
        step(1'b0, 32'hF7654311);
        lit("r_fields", 8'h11, 4'h3, 4'h4, 4'h5, 4'hF, 24'h000076, 3'b000);
        step(1'b0, 32'h2FFF8721);
        lit("m_sext", 8'h21, 4'h7, 4'h8, 4'h0, 4'h2, 24'hFFFFFF, 3'b001);
        step(1'b0, 32'h12345601);
        lit("e_imm", 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 24'h123456, 3'b101);
        step(1'b0, 32'hFFFFFFFF);
        lit("invalid", 8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0, 3'b111);
        step(1'b0, 32'h80001240);
        lit("j_sext", 8'h40, 4'h2, 4'h0, 4'h0, 4'h0, 24'hF80001, 3'b011);
        step(1'b0, 32'hABCDE530);
        lit("f_fields", 8'h30, 4'h5, 4'hE, 4'h0, 4'hD, 24'h000ABC, 3'b010);
        step(1'b1, 32'h12345601);
        lit("mid_reset", 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0, 3'b111);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[7:0] = bounds[i];
            step(1'b0, w);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            logic        r;
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[7:0] = 8'($urandom_range(0, 96));
            r = ($urandom_range(0, 31) == 0);
            step(r, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all port names follow the codebase (clk, rst).
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 instruction  input  32  raw instruction word to decode.
REQ-005 opcode  output  8  registered copy of instruction[7:0].
REQ-006 rde  output  4  destination register index.
REQ-007 rs1  output  4  first source register index.
REQ-008 rs2  output  4  second source register index.
REQ-009 func  output  4  function/sub-operation field.
REQ-010 imm  output  24  immediate, extended to 24 bits per format.
REQ-011 instr_type  output  3  format code: R=000, M=001, F=010, J=011, B=100, E=101, invalid=111.

Function
REQ-012 All outputs SHALL be registered: decode of instruction sampled at rising edge N appears on the outputs after edge N, giving 1-cycle latency, with no combinational input-to-output path.
REQ-013 Format SHALL be selected by the opcode range:
- 0x01-0x0F -> E
- 0x10-0x1F -> R (ORR = 0x11)
- 0x20-0x2F -> M (ORI = 0x21)
- 0x30-0x3F -> F
- 0x40-0x4F -> J
- 0x50-0x5F -> B
- 0x00 and 0x60-0xFF -> invalid
REQ-014 R format SHALL decode rde=[11:8], rs1=[15:12], rs2=[19:16], imm=zero-extend([27:20]), func=[31:28].
REQ-015 M format SHALL decode rde=[11:8], rs1=[15:12], imm=sign-extend([27:16]), func=[31:28].
REQ-016 F format SHALL decode rde=[11:8], rs1=[15:12], func=[19:16], imm=zero-extend([31:20]).
REQ-017 J format SHALL decode rde=[11:8], imm=sign-extend([31:12]).
REQ-018 B format SHALL decode func=[11:8], imm=sign-extend([31:12]).
REQ-019 E format SHALL decode imm=[31:8], with no extension.
REQ-020 Fields unused by the decoded format SHALL be driven to 0.
REQ-021 Invalid opcodes SHALL drive opcode=instruction[7:0], instr_type=111, and all other fields 0.
REQ-022 opcode SHALL always equal the sampled instruction[7:0], regardless of format.
REQ-023 A changing instruction input SHALL be decoded independently every cycle, with no state retained between instructions.

Reset
REQ-024 While rst is high at a rising edge, the outputs SHALL become opcode=0x00, rde=rs1=rs2=func=0, imm=0x000000, and instr_type=111.
REQ-025 Reset SHALL take priority over decode: if rst is asserted mid-stream, the next edge yields reset values regardless of instruction.
REQ-026 The first edge after rst deasserts SHALL register the decode of the instruction present at that edge.

Verification
REQ-027 Reset: rst=1 with instruction=0xF7654311 -> after the edge, all fields 0 and instr_type=111.
REQ-028 ORR: instruction=0x00000011 -> one cycle later opcode=0x11, instr_type=000, all other fields 0; then instruction=0x00000021 (ORI) -> opcode=0x21, instr_type=001.
REQ-029 R fields: instruction=0xF7654311 -> rde=3, rs1=4, rs2=5, imm=0x000076, func=0xF, instr_type=000.
REQ-030 M sign extension: instruction=0x2FFF8721 -> rde=7, rs1=8, imm=0xFFFFFF, func=2, rs2=0, instr_type=001.
REQ-031 E and invalid: instruction=0x12345601 -> imm=0x123456, instr_type=101; instruction=0xFFFFFFFF -> opcode=0xFF, instr_type=111, other fields 0.
REQ-032 Back-to-back: a new instruction every cycle -> each decode appears exactly one cycle after it is applied, with no skipped or duplicated results.
